// File: rtl/fpu_divsqrt_pkg.sv
// Shared types and constants for the div/sqrt issue controller and its bench.
package fpu_divsqrt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int REC_W  = 33;
  localparam int FLAG_W = 5;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // f32 values in recoded (33-bit) form
  localparam logic [REC_W-1:0] REC_ZERO    = 33'h000000000;
  localparam logic [REC_W-1:0] REC_ONE     = 33'h080000000;
  localparam logic [REC_W-1:0] REC_TWO     = 33'h080800000;
  localparam logic [REC_W-1:0] REC_FOUR    = 33'h081000000;
  localparam logic [REC_W-1:0] REC_POS_INF = 33'h0C0000000;

  function automatic logic [FLAG_W-1:0] flag_mask(input int unsigned pos);
    return FLAG_W'(1) << pos;
  endfunction

endpackage

// File: rtl/div_sqrt_issue_ctrl.sv
// Requester-side controller for the recoded div/sqrt unit: launches one tagged
// operation, captures the result pulse and holds it for FPU writeback.
//
// state    | meaning
// ST_IDLE  | ready for a new request
// ST_ISSUE | operands registered, inValid asserted towards the unit
// ST_BUSY  | launched, waiting for the unit's result pulse
// ST_DONE  | result held, waiting for writeback handshake
module div_sqrt_issue_ctrl
  import fpu_divsqrt_pkg::*;
#(
  parameter int TAG_W       = 5,
  parameter int REC_W       = fpu_divsqrt_pkg::REC_W,
  parameter int HANG_CYCLES = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_req_valid,
  output logic             io_req_ready,
  input  logic             io_req_sqrt,
  input  logic [REC_W-1:0] io_req_a,
  input  logic [REC_W-1:0] io_req_b,
  input  logic [2:0]       io_req_rm,
  input  logic [TAG_W-1:0] io_req_tag,
  input  logic             io_kill,
  input  logic             io_div_inReady,
  output logic             io_div_inValid,
  output logic             io_div_sqrtOp,
  output logic [REC_W-1:0] io_div_a,
  output logic [REC_W-1:0] io_div_b,
  output logic [2:0]       io_div_roundingMode,
  input  logic             io_div_outValid_div,
  input  logic             io_div_outValid_sqrt,
  input  logic [REC_W-1:0] io_div_out,
  input  logic [4:0]       io_div_exceptionFlags,
  output logic             io_resp_valid,
  input  logic             io_resp_ready,
  output logic [REC_W-1:0] io_resp_data,
  output logic [4:0]       io_resp_flags,
  output logic [TAG_W-1:0] io_resp_tag,
  output logic             io_resp_sqrt,
  output logic             io_busy,
  output logic             io_protocol_err,
  output logic             io_hang
);

  localparam int HCNT_W = $clog2(HANG_CYCLES + 1);
  localparam logic [HCNT_W-1:0] HANG_MAX  = HCNT_W'(HANG_CYCLES);
  localparam logic [HCNT_W-1:0] HANG_LAST = HCNT_W'(HANG_CYCLES - 1);

  state_e r_state, w_state_nxt;

  logic             r_sqrt;
  logic [REC_W-1:0] r_a, r_b;
  logic [2:0]       r_rm;
  logic [TAG_W-1:0] r_tag;
  logic             r_killed;
  logic             r_div_in_valid, r_resp_valid, r_busy;
  logic             r_proto_err, r_hang;
  logic [REC_W-1:0] r_resp_data;
  logic [4:0]       r_resp_flags;
  logic [TAG_W-1:0] r_resp_tag;
  logic             r_resp_sqrt;
  logic [HCNT_W-1:0] r_hang_cnt;

  logic w_pulse, w_accept, w_launch, w_capture, w_proto_err;

  assign w_pulse = io_div_outValid_div | io_div_outValid_sqrt;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_launch    = 1'b0;
    w_capture   = 1'b0;
    w_proto_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_proto_err = w_pulse;
        if (io_req_valid && !io_kill) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_proto_err = w_pulse;
        // a kill coinciding with the launch cannot recall it; it is tracked as killed
        if (io_div_inReady) begin
          w_launch    = 1'b1;
          w_state_nxt = ST_BUSY;
        end else if (io_kill) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (w_pulse) begin
          w_proto_err = (io_div_outValid_div & io_div_outValid_sqrt) |
                        (io_div_outValid_sqrt != r_sqrt);
          if (r_killed || io_kill) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_proto_err = w_pulse;
        if (io_kill || io_resp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_sqrt         <= 1'b0;
      r_a            <= '0;
      r_b            <= '0;
      r_rm           <= '0;
      r_tag          <= '0;
      r_killed       <= 1'b0;
      r_div_in_valid <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_busy         <= 1'b0;
      r_proto_err    <= 1'b0;
      r_hang         <= 1'b0;
      r_resp_data    <= '0;
      r_resp_flags   <= '0;
      r_resp_tag     <= '0;
      r_resp_sqrt    <= 1'b0;
      r_hang_cnt     <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_div_in_valid <= (w_state_nxt == ST_ISSUE);
      r_resp_valid   <= (w_state_nxt == ST_DONE);
      r_busy         <= (w_state_nxt != ST_IDLE);

      if (w_accept) begin
        r_sqrt   <= io_req_sqrt;
        r_a      <= io_req_a;
        r_b      <= io_req_b;
        r_rm     <= io_req_rm;
        r_tag    <= io_req_tag;
        r_killed <= 1'b0;
      end else if ((w_launch || r_state == ST_BUSY) && io_kill) begin
        r_killed <= 1'b1;
      end

      if (w_launch) begin
        r_hang_cnt <= '0;
      end else if (r_state == ST_BUSY && r_hang_cnt != HANG_MAX) begin
        r_hang_cnt <= r_hang_cnt + 1'b1;
      end

      // flag rises on the same edge the counter reaches HANG_CYCLES
      if (r_state == ST_BUSY && r_hang_cnt == HANG_LAST) r_hang <= 1'b1;
      if (w_proto_err) r_proto_err <= 1'b1;

      if (w_capture) begin
        r_resp_data  <= io_div_out;
        r_resp_flags <= io_div_exceptionFlags;
        r_resp_tag   <= r_tag;
        r_resp_sqrt  <= r_sqrt;
      end
    end
  end

  assign io_req_ready        = (r_state == ST_IDLE);
  assign io_div_inValid      = r_div_in_valid;
  assign io_div_sqrtOp       = r_sqrt;
  assign io_div_a            = r_a;
  assign io_div_b            = r_b;
  assign io_div_roundingMode = r_rm;
  assign io_resp_valid       = r_resp_valid;
  assign io_resp_data        = r_resp_data;
  assign io_resp_flags       = r_resp_flags;
  assign io_resp_tag         = r_resp_tag;
  assign io_resp_sqrt        = r_resp_sqrt;
  assign io_busy             = r_busy;
  assign io_protocol_err     = r_proto_err;
  assign io_hang             = r_hang;

endmodule

// File: tb/tb_div_sqrt_issue_ctrl.sv
// Scoreboard bench for div_sqrt_issue_ctrl; the bench plays the div/sqrt unit
// and the writeback stage.
module tb_div_sqrt_issue_ctrl;
  import fpu_divsqrt_pkg::*;

  localparam int TB_TAG_W = 5;
  localparam int HANG     = 64;

  typedef struct {
    logic [REC_W-1:0]    data;
    logic [FLAG_W-1:0]   flags;
    logic [TB_TAG_W-1:0] tag;
    logic                sqrt;
  } resp_t;

  logic                clock = 1'b0;
  logic                reset;
  logic                io_req_valid, io_req_ready, io_req_sqrt;
  logic [REC_W-1:0]    io_req_a, io_req_b;
  logic [2:0]          io_req_rm;
  logic [TB_TAG_W-1:0] io_req_tag;
  logic                io_kill;
  logic                io_div_inReady, io_div_inValid, io_div_sqrtOp;
  logic [REC_W-1:0]    io_div_a, io_div_b;
  logic [2:0]          io_div_roundingMode;
  logic                io_div_outValid_div, io_div_outValid_sqrt;
  logic [REC_W-1:0]    io_div_out;
  logic [4:0]          io_div_exceptionFlags;
  logic                io_resp_valid, io_resp_ready;
  logic [REC_W-1:0]    io_resp_data;
  logic [4:0]          io_resp_flags;
  logic [TB_TAG_W-1:0] io_resp_tag;
  logic                io_resp_sqrt, io_busy, io_protocol_err, io_hang;

  int    n_checks = 0;
  int    n_fail   = 0;
  resp_t sb_q[$];

  div_sqrt_issue_ctrl #(.TAG_W(TB_TAG_W), .REC_W(REC_W), .HANG_CYCLES(HANG)) dut (
    .clock(clock), .reset(reset),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_sqrt(io_req_sqrt), .io_req_a(io_req_a), .io_req_b(io_req_b),
    .io_req_rm(io_req_rm), .io_req_tag(io_req_tag), .io_kill(io_kill),
    .io_div_inReady(io_div_inReady), .io_div_inValid(io_div_inValid),
    .io_div_sqrtOp(io_div_sqrtOp), .io_div_a(io_div_a), .io_div_b(io_div_b),
    .io_div_roundingMode(io_div_roundingMode),
    .io_div_outValid_div(io_div_outValid_div), .io_div_outValid_sqrt(io_div_outValid_sqrt),
    .io_div_out(io_div_out), .io_div_exceptionFlags(io_div_exceptionFlags),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_data(io_resp_data), .io_resp_flags(io_resp_flags),
    .io_resp_tag(io_resp_tag), .io_resp_sqrt(io_resp_sqrt),
    .io_busy(io_busy), .io_protocol_err(io_protocol_err), .io_hang(io_hang)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic sqrt, input logic [REC_W-1:0] a, input logic [REC_W-1:0] b,
                       input logic [2:0] rm, input logic [TB_TAG_W-1:0] tag);
    int n = 0;
    while (!io_req_ready && n < 20) begin
      step();
      n++;
    end
    check("req_ready_before_issue", 64'(io_req_ready), 64'(1));
    io_req_valid = 1'b1;
    io_req_sqrt  = sqrt;
    io_req_a     = a;
    io_req_b     = b;
    io_req_rm    = rm;
    io_req_tag   = tag;
    step();
    io_req_valid = 1'b0;
    io_req_a     = '0;
    io_req_b     = '0;
    check("inValid_n1", 64'(io_div_inValid), 64'(1));
    check("div_a", 64'(io_div_a), 64'(a));
    check("div_b", 64'(io_div_b), 64'(b));
    check("div_sqrtOp", 64'(io_div_sqrtOp), 64'(sqrt));
    check("div_rm", 64'(io_div_roundingMode), 64'(rm));
    check("req_ready_issue", 64'(io_req_ready), 64'(0));
  endtask

  task automatic launch(input int delay);
    for (int i = 0; i < delay; i++) begin
      step();
      check("inValid_hold", 64'(io_div_inValid), 64'(1));
    end
    io_div_inReady = 1'b1;
    step();
    io_div_inReady = 1'b0;
    check("inValid_drop", 64'(io_div_inValid), 64'(0));
    check("busy_launched", 64'(io_busy), 64'(1));
  endtask

  task automatic unit_pulse(input int wait_cyc, input logic pv_div, input logic pv_sqrt,
                            input logic [REC_W-1:0] data, input logic [4:0] flags,
                            input logic exp_valid);
    for (int i = 0; i < wait_cyc; i++) begin
      check("no_early_resp", 64'(io_resp_valid), 64'(0));
      step();
    end
    io_div_outValid_div   = pv_div;
    io_div_outValid_sqrt  = pv_sqrt;
    io_div_out            = data;
    io_div_exceptionFlags = flags;
    step();
    io_div_outValid_div   = 1'b0;
    io_div_outValid_sqrt  = 1'b0;
    io_div_out            = '0;
    io_div_exceptionFlags = '0;
    check("resp_valid_m1", 64'(io_resp_valid), 64'(exp_valid));
  endtask

  task automatic collect(input int delay);
    resp_t e;
    check("sb_pending", 64'(sb_q.size() > 0), 64'(1));
    if (sb_q.size() == 0) return;
    e = sb_q[0];
    for (int i = 0; i < delay; i++) begin
      check("bp_valid", 64'(io_resp_valid), 64'(1));
      check("bp_data", 64'(io_resp_data), 64'(e.data));
      check("bp_tag", 64'(io_resp_tag), 64'(e.tag));
      check("bp_req_ready", 64'(io_req_ready), 64'(0));
      step();
    end
    io_resp_ready = 1'b1;
    e = sb_q.pop_front();
    check("resp_valid", 64'(io_resp_valid), 64'(1));
    check("resp_data", 64'(io_resp_data), 64'(e.data));
    check("resp_flags", 64'(io_resp_flags), 64'(e.flags));
    check("resp_tag", 64'(io_resp_tag), 64'(e.tag));
    check("resp_sqrt", 64'(io_resp_sqrt), 64'(e.sqrt));
    step();
    io_resp_ready = 1'b0;
    check("resp_valid_after_hs", 64'(io_resp_valid), 64'(0));
    check("req_ready_k1", 64'(io_req_ready), 64'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(io_req_ready), 64'(1));
    check({tag, "_inValid"}, 64'(io_div_inValid), 64'(0));
    check({tag, "_resp_valid"}, 64'(io_resp_valid), 64'(0));
    check({tag, "_busy"}, 64'(io_busy), 64'(0));
    check({tag, "_perr"}, 64'(io_protocol_err), 64'(0));
    check({tag, "_hang"}, 64'(io_hang), 64'(0));
    check({tag, "_resp_data"}, 64'(io_resp_data), 64'(0));
    check({tag, "_resp_tag"}, 64'(io_resp_tag), 64'(0));
    check({tag, "_resp_flags"}, 64'(io_resp_flags), 64'(0));
    check({tag, "_div_a"}, 64'(io_div_a), 64'(0));
  endtask

  initial begin
    reset = 1'b1;
    io_req_valid = 1'b0; io_req_sqrt = 1'b0; io_req_a = '0; io_req_b = '0;
    io_req_rm = '0; io_req_tag = '0; io_kill = 1'b0; io_div_inReady = 1'b0;
    io_div_outValid_div = 1'b0; io_div_outValid_sqrt = 1'b0; io_div_out = '0;
    io_div_exceptionFlags = '0; io_resp_ready = 1'b0;
    repeat (3) step();
    check_reset_outputs("rst");
    reset = 1'b0;
    step();

    // basic divide 2.0 / 1.0
    issue(1'b0, REC_TWO, REC_ONE, 3'd0, 5'd7);
    sb_q.push_back('{data: REC_TWO, flags: 5'h00, tag: 5'd7, sqrt: 1'b0});
    launch(3);
    unit_pulse(5, 1'b1, 1'b0, REC_TWO, 5'h00, 1'b1);
    collect(0);

    // sqrt(4.0) with writeback backpressure
    issue(1'b1, REC_FOUR, REC_ZERO, 3'd1, 5'd12);
    sb_q.push_back('{data: REC_TWO, flags: 5'h00, tag: 5'd12, sqrt: 1'b1});
    launch(0);
    unit_pulse(4, 1'b0, 1'b1, REC_TWO, 5'h00, 1'b1);
    collect(10);

    // divide by zero
    issue(1'b0, REC_ONE, REC_ZERO, 3'd2, 5'd3);
    sb_q.push_back('{data: REC_POS_INF, flags: flag_mask(FLAG_DZ), tag: 5'd3, sqrt: 1'b0});
    launch(1);
    unit_pulse(2, 1'b1, 1'b0, REC_POS_INF, flag_mask(FLAG_DZ), 1'b1);
    collect(2);

    // kill in ISSUE before the unit is ready
    issue(1'b0, REC_TWO, REC_ONE, 3'd0, 5'd20);
    step();
    step();
    io_kill = 1'b1;
    step();
    io_kill = 1'b0;
    check("killiss_inValid", 64'(io_div_inValid), 64'(0));
    check("killiss_busy", 64'(io_busy), 64'(0));
    check("killiss_req_ready", 64'(io_req_ready), 64'(1));
    io_div_inReady = 1'b1;
    step();
    io_div_inReady = 1'b0;
    check("killiss_no_launch", 64'(io_div_inValid), 64'(0));

    // kill in BUSY, then a clean follow-up request
    issue(1'b1, REC_FOUR, REC_ZERO, 3'd0, 5'd21);
    launch(0);
    step();
    io_kill = 1'b1;
    step();
    io_kill = 1'b0;
    unit_pulse(3, 1'b0, 1'b1, REC_TWO, 5'h00, 1'b0);
    check("killbusy_idle", 64'(io_busy), 64'(0));
    step();
    check("killbusy_no_resp", 64'(io_resp_valid), 64'(0));
    issue(1'b0, REC_TWO, REC_ONE, 3'd0, 5'd9);
    sb_q.push_back('{data: REC_TWO, flags: 5'h00, tag: 5'd9, sqrt: 1'b0});
    launch(0);
    unit_pulse(1, 1'b1, 1'b0, REC_TWO, 5'h00, 1'b1);
    collect(1);
    check("perr_clean", 64'(io_protocol_err), 64'(0));

    // divide answered with a sqrt pulse: flagged, result still delivered
    issue(1'b0, REC_TWO, REC_ONE, 3'd0, 5'd5);
    sb_q.push_back('{data: REC_TWO, flags: 5'h00, tag: 5'd5, sqrt: 1'b0});
    launch(0);
    unit_pulse(2, 1'b0, 1'b1, REC_TWO, 5'h00, 1'b1);
    check("perr_mismatch", 64'(io_protocol_err), 64'(1));
    collect(0);

    // reset while BUSY
    issue(1'b1, REC_FOUR, REC_ZERO, 3'd3, 5'd30);
    launch(0);
    step();
    reset = 1'b1;
    step();
    check_reset_outputs("midrst");
    reset = 1'b0;
    step();

    // stray pulse in IDLE
    check("perr_pre_idle", 64'(io_protocol_err), 64'(0));
    io_div_outValid_sqrt = 1'b1;
    step();
    io_div_outValid_sqrt = 1'b0;
    check("perr_idle", 64'(io_protocol_err), 64'(1));
    repeat (3) step();
    check("perr_sticky", 64'(io_protocol_err), 64'(1));

    // hang: unit never answers
    issue(1'b0, REC_TWO, REC_ONE, 3'd0, 5'd1);
    launch(0);
    for (int n = 1; n <= HANG; n++) begin
      step();
      if (n == HANG - 1) check("hang_early", 64'(io_hang), 64'(0));
      if (n == HANG) check("hang_set", 64'(io_hang), 64'(1));
    end
    repeat (4) step();
    check("hang_sticky", 64'(io_hang), 64'(1));
    check("hang_busy", 64'(io_busy), 64'(1));

    check("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
